fifo_write_arbiter: RTL and testbench

//  Round-robin scheduler sharing the write port of one synchronousFifoSerialToParallelParameterized

---
 rtl/fifo_write_arbiter_pkg.sv | 13 +
 rtl/rr_priority_picker.sv | 31 +++
 rtl/fifo_write_arbiter.sv | 96 +++++++++
 tb/tb_fifo_write_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_write_arbiter_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM state encoding and the
// default beat geometry that the downstream split FIFO is built with.
package fifo_write_arbiter_pkg;

    localparam int DEF_SPLIT_WIDTH = 128;
    localparam int DEF_NUM_SPLITS  = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: returns the first requester at or after
// rrPtr (modulo NUM_REQ) that has its request bit set.
module rr_priority_picker #(
    parameter int NUM_REQ  = 4,
    parameter int REQ_BITS = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [REQ_BITS-1:0] rrPtr,
    output logic [REQ_BITS-1:0] winner,
    output logic                anyReq
);

    int w_best_dist;
    int w_dist;

    always_comb begin
        winner      = '0;
        anyReq      = |req;
        w_best_dist = NUM_REQ;
        w_dist      = 0;
        // Distance from the pointer going forward; the smallest distance wins.
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = (i - int'(rrPtr) + NUM_REQ) % NUM_REQ;
            if (req[i] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                winner      = REQ_BITS'(i);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that captures one requester's full word and streams it
// into the split FIFO as NUM_SPLITS beats, low slice first.
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int SPLIT_WIDTH          = DEF_SPLIT_WIDTH,
    parameter int NUM_SPLITS           = DEF_NUM_SPLITS,
    parameter int NUM_SPLITS_BIT_WIDTH = 1,
    parameter int NUM_REQ              = 4,
    parameter int REQ_BITS             = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_REQ-1:0]                       req,
    input  logic [NUM_REQ*NUM_SPLITS*SPLIT_WIDTH-1:0] reqData,
    output logic [NUM_REQ-1:0]                       ack,
    input  logic                                     fifoFull,
    output logic [SPLIT_WIDTH-1:0]                   fifoData,
    output logic                                     fifoValid,
    output logic                                     busy,
    output logic [REQ_BITS-1:0]                      owner
);

    localparam int WORD_W = NUM_SPLITS * SPLIT_WIDTH;

    state_t                          r_state;
    logic [NUM_SPLITS_BIT_WIDTH-1:0] r_beat;
    logic [REQ_BITS-1:0]             r_rr_ptr;
    logic [REQ_BITS-1:0]             r_owner;
    logic [WORD_W-1:0]               r_word;

    logic [REQ_BITS-1:0]                  w_winner;
    logic                                 w_any_req;
    logic                                 w_grant;
    logic                                 w_last_beat;
    logic [NUM_REQ-1:0][WORD_W-1:0]       w_req_words;
    logic [NUM_SPLITS-1:0][SPLIT_WIDTH-1:0] w_slices;

    rr_priority_picker #(
        .NUM_REQ  (NUM_REQ),
        .REQ_BITS (REQ_BITS)
    ) u_picker (
        .req    (req),
        .rrPtr  (r_rr_ptr),
        .winner (w_winner),
        .anyReq (w_any_req)
    );

    assign w_req_words = reqData;
    assign w_slices    = r_word;

    // No ack while reset is held: nothing is captured, so no requester may move on.
    assign w_grant     = (r_state == ST_IDLE) && w_any_req && !rst;
    assign w_last_beat = (r_beat == NUM_SPLITS_BIT_WIDTH'(NUM_SPLITS - 1));

    assign ack       = w_grant ? (NUM_REQ'(1) << w_winner) : '0;
    assign fifoValid = (r_state == ST_SEND) && !fifoFull;
    assign fifoData  = (r_state == ST_SEND) ? w_slices[r_beat] : '0;
    assign busy      = (r_state == ST_SEND);
    assign owner     = r_owner;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_beat   <= '0;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_word   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_word  <= w_req_words[w_winner];
                        r_owner <= w_winner;
                        r_beat  <= '0;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (fifoValid) begin
                        if (w_last_beat) begin
                            r_beat   <= '0;
                            r_rr_ptr <= (r_owner == REQ_BITS'(NUM_REQ - 1)) ?
                                        '0 : r_owner + REQ_BITS'(1);
                            r_state  <= ST_IDLE;
                        end else begin
                            r_beat <= r_beat + NUM_SPLITS_BIT_WIDTH'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized and directed checks of fifo_write_arbiter against a queue-based
// transaction model; a second instance covers the 4-beat, 3-requester build.
module tb_fifo_write_arbiter;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    req = '0;
    logic [1023:0] reqData = '0;
    logic [3:0]    ack;
    logic          fifoFull = 1'b0;
    logic [127:0]  fifoData;
    logic          fifoValid;
    logic          busy;
    logic [1:0]    owner;

    logic [2:0]    req1 = '0;
    logic [191:0]  reqData1 = '0;
    logic [2:0]    ack1;
    logic          fifoFull1 = 1'b0;
    logic [15:0]   fifoData1;
    logic          fifoValid1;
    logic          busy1;
    logic [1:0]    owner1;

    always #5 clk = ~clk;

    fifo_write_arbiter #(
        .SPLIT_WIDTH(128), .NUM_SPLITS(2), .NUM_SPLITS_BIT_WIDTH(1), .NUM_REQ(4), .REQ_BITS(2)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .reqData(reqData), .ack(ack),
        .fifoFull(fifoFull), .fifoData(fifoData), .fifoValid(fifoValid),
        .busy(busy), .owner(owner)
    );

    fifo_write_arbiter #(
        .SPLIT_WIDTH(16), .NUM_SPLITS(4), .NUM_SPLITS_BIT_WIDTH(2), .NUM_REQ(3), .REQ_BITS(2)
    ) dut4 (
        .clk(clk), .rst(rst), .req(req1), .reqData(reqData1), .ack(ack1),
        .fifoFull(fifoFull1), .fifoData(fifoData1), .fifoValid(fifoValid1),
        .busy(busy1), .owner(owner1)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: remaining beats of the word in flight, pointer, owner.
    logic [127:0] m_q[$];
    logic [255:0] sb_q[$];
    int           m_rr = 0;
    int           m_owner = 0;
    logic [255:0] asm_word = '0;
    int           asm_n = 0;
    int           vcount = 0;
    int           grants[$];

    logic [3:0]   o_ack;
    logic         o_vld;
    logic [127:0] o_data;
    logic         o_busy;
    logic [3:0]   last_ack = '0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic new_data(input int i);
        for (int j = 0; j < 8; j++) reqData[i*256 + j*32 +: 32] = $urandom;
    endtask

    task automatic step();
        logic [3:0]   e_ack;
        logic         e_vld;
        logic [127:0] e_data;
        logic [255:0] wd;
        int           w;
        @(negedge clk);
        e_ack = '0; e_vld = 1'b0; e_data = '0; w = -1;
        if (m_q.size() == 0) begin
            for (int k = 0; k < 4; k++)
                if (w < 0 && req[(m_rr + k) % 4]) w = (m_rr + k) % 4;
            if (w >= 0) e_ack[w] = 1'b1;
        end else begin
            e_vld  = !fifoFull;
            e_data = m_q[0];
        end
        o_ack = ack; o_vld = fifoValid; o_data = fifoData; o_busy = busy;
        chk("ack", 256'(ack), 256'(e_ack));
        chk("valid", 256'(fifoValid), 256'(e_vld));
        chk("data", 256'(fifoData), 256'(e_data));
        chk("busy", 256'(busy), 256'(m_q.size() != 0));
        chk("owner", 256'(owner), 256'(m_owner));
        if (!busy) chk("align", 256'(vcount % 2), 256'(0));
        if (fifoValid) begin
            vcount++;
            asm_word[asm_n*128 +: 128] = fifoData;
            asm_n++;
            if (asm_n == 2) begin
                if (sb_q.size() == 0) chk("sb_extra_word", asm_word, 256'(0) - 256'(1));
                else chk("sb_word", asm_word, sb_q.pop_front());
                asm_n = 0;
            end
        end
        for (int i = 0; i < 4; i++) if (ack[i]) grants.push_back(i);
        if (w >= 0) begin
            wd = reqData[w*256 +: 256];
            m_q.push_back(wd[127:0]);
            m_q.push_back(wd[255:128]);
            m_owner = w;
            sb_q.push_back(wd);
        end else if (e_vld) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_rr = (m_owner + 1) % 4;
        end
        last_ack = ack;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_ack", 256'(ack), 256'(0));
        chk("rst_valid", 256'(fifoValid), 256'(0));
        chk("rst_data", 256'(fifoData), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_owner", 256'(owner), 256'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        m_q.delete(); sb_q.delete();
        m_rr = 0; m_owner = 0; asm_n = 0; vcount = 0; last_ack = '0;
    endtask

    task automatic gen_req();
        for (int i = 0; i < 4; i++) begin
            if (last_ack[i]) begin
                req[i] = 1'($urandom_range(0, 1));
                new_data(i);
            end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                req[i] = 1'b1;
                new_data(i);
            end
        end
    endtask

    task automatic test_wide();
        logic [63:0] wd;
        logic [63:0] got;
        int          r, nb;
        logic        seen;
        for (int n = 0; n < 6; n++) begin
            r  = (n == 0) ? 1 : $urandom_range(0, 2);
            wd = (n == 0) ? 64'hDDDD_CCCC_BBBB_AAAA : {$urandom, $urandom};
            reqData1[r*64 +: 64] = wd;
            req1 = '0; req1[r] = 1'b1;
            fifoFull1 = 1'b0;
            got = '0; nb = 0; seen = 1'b0;
            for (int c = 0; c < 40 && nb < 4; c++) begin
                @(negedge clk);
                if (ack1 != 3'b000) begin
                    seen = 1'b1;
                    if (n == 0) chk("w4_ack", 256'(ack1), 256'(3'b010));
                end
                if (fifoValid1) begin
                    got[nb*16 +: 16] = fifoData1;
                    nb++;
                end
                @(posedge clk); #1;
                if (seen) req1 = '0;
                fifoFull1 = (n > 0) && ($urandom_range(0, 3) == 0);
            end
            chk("w4_acked", 256'(seen), 256'(1));
            chk("w4_word", 256'(got), 256'(wd));
            fifoFull1 = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [255:0] w3;
        repeat (2) @(posedge clk);
        #1;

        // 1: single request, two beats, then idle
        do_reset();
        reqData[2*256 +: 256] = {128'hBBBB_0000_0000_0000_0000_0000_0000_000B,
                                 128'hAAAA_0000_0000_0000_0000_0000_0000_000A};
        req = 4'b0100;
        step(); chk("t1_ack", 256'(o_ack), 256'(4'b0100));
        req = 4'b0000;
        step(); chk("t1_beatA", 256'({o_vld, o_data}), {127'd0, 1'b1, 128'hAAAA_0000_0000_0000_0000_0000_0000_000A});
        step(); chk("t1_beatB", 256'({o_vld, o_data}), {127'd0, 1'b1, 128'hBBBB_0000_0000_0000_0000_0000_0000_000B});
        step(); chk("t1_idle", 256'(o_busy), 256'(0));

        // 4: pointer now at 3, requests 3 and 0 -> 3 first, then wrap to 0, then 1
        grants.delete();
        new_data(0); new_data(3);
        req = 4'b1001;
        for (int c = 0; c < 8; c++) begin
            step();
            for (int i = 0; i < 4; i++) if (o_ack[i]) req[i] = 1'b0;
        end
        chk("t4_n", 256'(grants.size()), 256'(2));
        if (grants.size() >= 2) begin
            chk("t4_first", 256'(grants[0]), 256'(3));
            chk("t4_second", 256'(grants[1]), 256'(0));
        end
        for (int i = 0; i < 4; i++) new_data(i);
        req = 4'b1111;
        step(); chk("t4_next", 256'(o_ack), 256'(4'b0010));

        // 2: all requesting continuously
        do_reset();
        grants.delete();
        for (int i = 0; i < 4; i++) new_data(i);
        req = 4'b1111;
        for (int c = 0; c < 15; c++) begin
            step();
            for (int i = 0; i < 4; i++) if (o_ack[i]) new_data(i);
        end
        chk("t2_n", 256'(grants.size()), 256'(5));
        for (int k = 0; k < 5 && k < grants.size(); k++)
            chk("t2_order", 256'(grants[k]), 256'(k % 4));

        // 3: stall on the second beat
        do_reset();
        new_data(0);
        w3 = reqData[255:0];
        req = 4'b0001;
        step();
        req = 4'b0000;
        step(); chk("t3_beat0", 256'(o_data), 256'(w3[127:0]));
        fifoFull = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("t3_stall_vld", 256'(o_vld), 256'(0));
            chk("t3_stall_data", 256'(o_data), 256'(w3[255:128]));
        end
        fifoFull = 1'b0;
        step(); chk("t3_beat1", 256'({o_vld, o_data}), {127'd0, 1'b1, w3[255:128]});
        step(); chk("t3_once", 256'({o_busy, o_vld}), 256'(0));

        // 5: reset mid-word, then a clean word
        new_data(1);
        req = 4'b0010;
        step();
        req = 4'b0000;
        step();
        do_reset();
        new_data(2);
        req = 4'b0100;
        step();
        req = 4'b0000;
        repeat (3) step();
        chk("t5_drained", 256'(sb_q.size()), 256'(0));

        // random traffic with backpressure
        do_reset();
        req = '0;
        for (int c = 0; c < 1500; c++) begin
            fifoFull = ($urandom_range(0, 9) < 3);
            step();
            gen_req();
        end
        fifoFull = 1'b0;
        req = '0;
        repeat (4) step();
        chk("rand_drained", 256'(sb_q.size()), 256'(0));

        // 6: four-beat build
        test_wide();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
